// File: rtl/sparse_stream_pkg.sv
// Shared definitions for the sparse stream sink blocks.
//
// Contents:
//   DATA_W       stream word width; the top bit flags a control token
//   DONE_TOKEN   canonical end-of-stream control word
//   tok_kind_t   classification of a single stream word
//   sink_state_t state encoding of the joined stream sink
//   tok_kind()   decodes one stream word into its token kind
package sparse_stream_pkg;

    localparam int DATA_W = 17;

    localparam logic [DATA_W-1:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        TK_DATA,
        TK_STOP,
        TK_DONE,
        TK_BAD
    } tok_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } sink_state_t;

    // Control words carry their type in bits [9:8]: 00 is a stop token whose
    // level is in bits [7:0], 01 is DONE, and anything else is malformed.
    function automatic tok_kind_t tok_kind(input logic [DATA_W-1:0] word);
        tok_kind_t kind;
        if (!word[DATA_W-1]) begin
            kind = TK_DATA;
        end else begin
            case (word[9:8])
                2'b00:   kind = TK_STOP;
                2'b01:   kind = TK_DONE;
                default: kind = TK_BAD;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry ready/valid FIFO used on each input channel of the sink.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clk_en       global enable; nothing moves while low
//   flush        synchronous clear of all contents
//   allow        upstream gating from the owner (tile enable, FSM state)
//   in_*         write side ready/valid
//   out_*        read side ready/valid; out_data is the head entry
module stream_fifo2
    import sparse_stream_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         flush,
    input  logic         allow,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Ready depends only on the registered fill level, so a full FIFO stalls
    // the sender even if the reader pops in the same cycle. Two entries are
    // enough to keep one beat per cycle flowing when the reader pops steadily.
    assign in_ready  = allow & clk_en & ~flush & (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready & clk_en & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/joined_stream_sink.sv
// Three-channel receiver for the joiner output triple (coord, pos0, pos1).
// Each channel is buffered in a 2-entry FIFO; when all three have a word the
// heads are popped together as one aligned beat, classified, and used to
// update the statistics. A kind mismatch or malformed control word is a
// sticky error; DONE on all three channels is a sticky completion.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   clk_en              global enable; all state holds and readies drop when low
//   flush               synchronous clear of everything (wins over clk_en)
//   tile_en             0 drops all readies and freezes state
//   coord_in*, pos_in_0*, pos_in_1*   ready/valid input streams
//   done, error         sticky terminal indications
//   data_count          aligned data beats consumed
//   stop_count          aligned stop beats consumed
//   max_stop_lvl        highest stop level seen
//   last_fiber_len      data beats between the two most recent stop beats
//   cycle_count         enabled cycles from first accepted word to DONE
module joined_stream_sink
#(
    parameter int DATA_W = sparse_stream_pkg::DATA_W,
    parameter int CNT_W  = 32,
    parameter int CYC_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic [DATA_W-1:0] coord_in,
    input  logic              coord_in_valid,
    output logic              coord_in_ready,
    input  logic [DATA_W-1:0] pos_in_0,
    input  logic              pos_in_0_valid,
    output logic              pos_in_0_ready,
    input  logic [DATA_W-1:0] pos_in_1,
    input  logic              pos_in_1_valid,
    output logic              pos_in_1_ready,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  data_count,
    output logic [CNT_W-1:0]  stop_count,
    output logic [7:0]        max_stop_lvl,
    output logic [CNT_W-1:0]  last_fiber_len,
    output logic [CYC_W-1:0]  cycle_count
);

    import sparse_stream_pkg::*;

    sink_state_t       state;
    sink_state_t       state_next;
    logic              en;
    logic              ready_armed;
    logic              allow;
    logic              join_fire;
    logic              any_push;
    logic              all_valid;
    logic [DATA_W-1:0] c_data;
    logic [DATA_W-1:0] p0_data;
    logic [DATA_W-1:0] p1_data;
    logic              c_valid;
    logic              p0_valid;
    logic              p1_valid;
    tok_kind_t         kind_c;
    tok_kind_t         kind_0;
    tok_kind_t         kind_1;
    tok_kind_t         beat_kind;
    logic [7:0]        stop_lvl;
    logic [CNT_W-1:0]  fiber_cnt;

    assign en = clk_en & tile_en;

    // Readies stay low for one cycle after reset or flush, and permanently
    // once the sink has reached a terminal state.
    assign allow = tile_en & ready_armed & ((state == ST_IDLE) || (state == ST_RUN));

    stream_fifo2 #(.W(DATA_W)) u_fifo_coord (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .flush     (flush),
        .allow     (allow),
        .in_data   (coord_in),
        .in_valid  (coord_in_valid),
        .in_ready  (coord_in_ready),
        .out_data  (c_data),
        .out_valid (c_valid),
        .out_ready (join_fire)
    );

    stream_fifo2 #(.W(DATA_W)) u_fifo_pos0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .flush     (flush),
        .allow     (allow),
        .in_data   (pos_in_0),
        .in_valid  (pos_in_0_valid),
        .in_ready  (pos_in_0_ready),
        .out_data  (p0_data),
        .out_valid (p0_valid),
        .out_ready (join_fire)
    );

    stream_fifo2 #(.W(DATA_W)) u_fifo_pos1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .flush     (flush),
        .allow     (allow),
        .in_data   (pos_in_1),
        .in_valid  (pos_in_1_valid),
        .in_ready  (pos_in_1_ready),
        .out_data  (p1_data),
        .out_valid (p1_valid),
        .out_ready (join_fire)
    );

    assign any_push  = (coord_in_valid & coord_in_ready)
                     | (pos_in_0_valid & pos_in_0_ready)
                     | (pos_in_1_valid & pos_in_1_ready);
    assign all_valid = c_valid & p0_valid & p1_valid;

    // Only token kinds are compared across channels; data payloads and stop
    // levels on the position streams are not checked. The stop level is
    // taken from the coordinate channel.
    assign kind_c   = tok_kind(c_data);
    assign kind_0   = tok_kind(p0_data);
    assign kind_1   = tok_kind(p1_data);
    assign stop_lvl = c_data[7:0];

    assign beat_kind = ((kind_c == TK_BAD) || (kind_c != kind_0) || (kind_c != kind_1))
                     ? TK_BAD : kind_c;

    // The first ready is re-armed one enabled cycle after reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_armed <= 1'b0;
        end else if (flush) begin
            ready_armed <= 1'b0;
        end else if (clk_en) begin
            ready_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (flush) begin
            state <= ST_IDLE;
        end else if (en) begin
            state <= state_next;
        end
    end

    // A beat is joined only in RUN and only when every channel has a word;
    // the three FIFOs always pop together so the channels stay aligned.
    always_comb begin
        state_next = state;
        join_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_push) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en && !flush && all_valid) begin
                    join_fire = 1'b1;
                    if (beat_kind == TK_DONE) begin
                        state_next = ST_DONE;
                    end else if (beat_kind == TK_BAD) begin
                        state_next = ST_ERR;
                    end
                end
            end
            ST_DONE: state_next = ST_DONE;
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_IDLE;
        endcase
    end

    assign done  = (state == ST_DONE);
    assign error = (state == ST_ERR);

    // All counters saturate at all-ones rather than wrapping. cycle_count
    // advances on every enabled cycle spent in RUN, which includes the cycle
    // the DONE beat is joined, and freezes once the sink is terminal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_count     <= '0;
            stop_count     <= '0;
            max_stop_lvl   <= '0;
            last_fiber_len <= '0;
            fiber_cnt      <= '0;
            cycle_count    <= '0;
        end else if (flush) begin
            data_count     <= '0;
            stop_count     <= '0;
            max_stop_lvl   <= '0;
            last_fiber_len <= '0;
            fiber_cnt      <= '0;
            cycle_count    <= '0;
        end else if (en) begin
            if ((state == ST_RUN) && (cycle_count != '1)) begin
                cycle_count <= cycle_count + CYC_W'(1);
            end
            if (join_fire) begin
                case (beat_kind)
                    TK_DATA: begin
                        if (data_count != '1) begin
                            data_count <= data_count + CNT_W'(1);
                        end
                        if (fiber_cnt != '1) begin
                            fiber_cnt <= fiber_cnt + CNT_W'(1);
                        end
                    end
                    TK_STOP: begin
                        if (stop_count != '1) begin
                            stop_count <= stop_count + CNT_W'(1);
                        end
                        last_fiber_len <= fiber_cnt;
                        fiber_cnt      <= '0;
                        if (stop_lvl > max_stop_lvl) begin
                            max_stop_lvl <= stop_lvl;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joined_stream_sink.sv
// Scoreboard bench for joined_stream_sink. Each directed stream pushes its
// hand-computed final statistics into a queue; a monitor pops and compares
// whenever the sink raises done or error.
module tb_joined_stream_sink;

    localparam int DW = 17;
    localparam logic [DW-1:0] S0 = 17'h10000;
    localparam logic [DW-1:0] S1 = 17'h10001;
    localparam logic [DW-1:0] DN = 17'h10100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic          flush;
    logic          tile_en;
    logic [DW-1:0] coord_in;
    logic          coord_in_valid;
    logic          coord_in_ready;
    logic [DW-1:0] pos_in_0;
    logic          pos_in_0_valid;
    logic          pos_in_0_ready;
    logic [DW-1:0] pos_in_1;
    logic          pos_in_1_valid;
    logic          pos_in_1_ready;
    logic          done;
    logic          error;
    logic [31:0]   data_count;
    logic [31:0]   stop_count;
    logic [7:0]    max_stop_lvl;
    logic [31:0]   last_fiber_len;
    logic [63:0]   cycle_count;

    always #5 clk = ~clk;

    joined_stream_sink dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en),
        .flush          (flush),
        .tile_en        (tile_en),
        .coord_in       (coord_in),
        .coord_in_valid (coord_in_valid),
        .coord_in_ready (coord_in_ready),
        .pos_in_0       (pos_in_0),
        .pos_in_0_valid (pos_in_0_valid),
        .pos_in_0_ready (pos_in_0_ready),
        .pos_in_1       (pos_in_1),
        .pos_in_1_valid (pos_in_1_valid),
        .pos_in_1_ready (pos_in_1_ready),
        .done           (done),
        .error          (error),
        .data_count     (data_count),
        .stop_count     (stop_count),
        .max_stop_lvl   (max_stop_lvl),
        .last_fiber_len (last_fiber_len),
        .cycle_count    (cycle_count)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic        done;
        logic        error;
        logic [31:0] data;
        logic [31:0] stop;
        logic [7:0]  maxl;
        logic [31:0] len;
        logic [63:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t make_exp(input int id, input logic d, input logic e,
                                      input int data, input int stop, input int maxl,
                                      input int len, input int cyc);
        exp_t x;
        x.id    = 8'(id);
        x.done  = d;
        x.error = e;
        x.data  = 32'(data);
        x.stop  = 32'(stop);
        x.maxl  = 8'(maxl);
        x.len   = 32'(len);
        x.cyc   = 64'(cyc);
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic set_chan(input int ch, input logic v, input logic [DW-1:0] w);
        case (ch)
            0: begin coord_in = w; coord_in_valid = v; end
            1: begin pos_in_0 = w; pos_in_0_valid = v; end
            default: begin pos_in_1 = w; pos_in_1_valid = v; end
        endcase
    endtask

    function automatic logic get_ready(input int ch);
        case (ch)
            0: return coord_in_ready;
            1: return pos_in_0_ready;
            default: return pos_in_1_ready;
        endcase
    endfunction

    // Offers each word from a negedge; ready is sampled mid-low-phase so the
    // handshake decision reflects the state that the next posedge will see.
    task automatic drive_chan(input int ch, input int delay, input logic [DW-1:0] words[$]);
        int   idx   = 0;
        int   guard = 0;
        logic took;
        repeat (delay) @(negedge clk);
        while (idx < words.size() && guard < 2000) begin
            set_chan(ch, 1'b1, words[idx]);
            #2;
            took = get_ready(ch);
            @(posedge clk);
            if (took) idx++;
            @(negedge clk);
            guard++;
        end
        set_chan(ch, 1'b0, '0);
        if (idx < words.size()) begin
            checkOutput($sformatf("chan%0d_accept_timeout", ch), 64'(idx), 64'(words.size()));
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] cw[$], input logic [DW-1:0] p0w[$],
                                 input logic [DW-1:0] p1w[$], input int p1_delay,
                                 input bit toggle, input bit push_exp, input exp_t e);
        bit tog_stop;
        tog_stop = 1'b0;
        if (push_exp) exp_q.push_back(e);
        fork
            begin
                fork
                    drive_chan(0, 0, cw);
                    drive_chan(1, 0, p0w);
                    drive_chan(2, p1_delay, p1w);
                join
                tog_stop = 1'b1;
            end
            begin
                if (toggle) begin
                    while (!tog_stop) begin
                        @(negedge clk);
                        if (!tog_stop) clk_en = ~clk_en;
                    end
                end
            end
        join
        clk_en = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: compares on each rising edge of done|error.
    initial begin : monitor
        logic term_prev;
        exp_t e;
        term_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if ((done | error) && !term_prev) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_terminal", 64'(done | error), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("s%0d.done", e.id), 64'(done), 64'(e.done));
                    checkOutput($sformatf("s%0d.error", e.id), 64'(error), 64'(e.error));
                    checkOutput($sformatf("s%0d.data_count", e.id), 64'(data_count), 64'(e.data));
                    checkOutput($sformatf("s%0d.stop_count", e.id), 64'(stop_count), 64'(e.stop));
                    checkOutput($sformatf("s%0d.max_stop_lvl", e.id), 64'(max_stop_lvl), 64'(e.maxl));
                    checkOutput($sformatf("s%0d.last_fiber_len", e.id), 64'(last_fiber_len), 64'(e.len));
                    checkOutput($sformatf("s%0d.cycle_count", e.id), cycle_count, e.cyc);
                end
            end
            term_prev = done | error;
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [DW-1:0] s1c[$];
        logic [DW-1:0] s1p0[$];
        logic [DW-1:0] s1p1[$];
        logic [DW-1:0] s3c[$];
        logic [DW-1:0] s3p0[$];
        logic [DW-1:0] s3p1[$];
        logic [DW-1:0] s4c[$];
        logic [DW-1:0] s4p0[$];
        logic [DW-1:0] s4p1[$];
        logic [DW-1:0] s5w[$];

        s1c  = '{17'h00011, 17'h00022, 17'h00033, 17'h00044, S0, DN};
        s1p0 = '{17'h00101, 17'h00102, 17'h00103, 17'h00104, S0, DN};
        s1p1 = '{17'h00201, 17'h00202, 17'h00203, 17'h00204, S0, DN};
        s3c  = '{S1};
        s3p0 = '{17'h00007};
        s3p1 = '{17'h00008};
        s4c  = '{17'h00001, 17'h00002, S0, S0, 17'h00003, 17'h00004, 17'h00005, S1, DN};
        s4p0 = '{17'h00a01, 17'h00a02, S0, S0, 17'h00a03, 17'h00a04, 17'h00a05, S1, DN};
        s4p1 = '{17'h00b01, 17'h00b02, S0, S0, 17'h00b03, 17'h00b04, 17'h00b05, S1, DN};
        s5w  = '{17'h00055, 17'h00066};

        rst_n   = 1'b0;
        clk_en  = 1'b1;
        flush   = 1'b0;
        tile_en = 1'b1;
        set_chan(0, 1'b0, '0);
        set_chan(1, 1'b0, '0);
        set_chan(2, 1'b0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst.done", 64'(done), 64'd0);
        checkOutput("rst.error", 64'(error), 64'd0);
        checkOutput("rst.data_count", 64'(data_count), 64'd0);
        checkOutput("rst.cycle_count", cycle_count, 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst.coord_ready_held", 64'(coord_in_ready), 64'd0);
        checkOutput("rst.pos1_ready_held", 64'(pos_in_1_ready), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("rst.coord_ready_armed", 64'(coord_in_ready), 64'd1);
        @(negedge clk);

        // 1: four data beats, S0, DONE, no stalls
        $display("[TB] scenario 1: basic stream");
        applyStimulus(s1c, s1p0, s1p1, 0, 1'b0, 1'b1, make_exp(1, 1, 0, 4, 1, 0, 4, 6));
        wait_drain("s1");
        checkOutput("s1.coord_ready_after_done", 64'(coord_in_ready), 64'd0);
        do_flush();

        // 2: pos_in_1 lags by three cycles; the other FIFOs fill and stall
        $display("[TB] scenario 2: delayed pos_in_1");
        fork
            applyStimulus(s1c, s1p0, s1p1, 3, 1'b0, 1'b1, make_exp(2, 1, 0, 4, 1, 0, 4, 9));
            begin
                repeat (2) @(negedge clk);
                #3;
                checkOutput("s2.coord_ready_full", 64'(coord_in_ready), 64'd0);
                checkOutput("s2.pos0_ready_full", 64'(pos_in_0_ready), 64'd0);
                checkOutput("s2.pos1_ready_empty", 64'(pos_in_1_ready), 64'd1);
            end
        join
        wait_drain("s2");
        do_flush();

        // 3: stop on coord against data on the position channels
        $display("[TB] scenario 3: kind mismatch");
        applyStimulus(s3c, s3p0, s3p1, 0, 1'b0, 1'b1, make_exp(3, 0, 1, 0, 0, 0, 0, 1));
        wait_drain("s3");
        checkOutput("s3.coord_ready_err", 64'(coord_in_ready), 64'd0);
        checkOutput("s3.pos0_ready_err", 64'(pos_in_0_ready), 64'd0);
        checkOutput("s3.pos1_ready_err", 64'(pos_in_1_ready), 64'd0);
        do_flush();

        // 4: fibers of length 2, 0, 3 closed by S0, S0, S1
        $display("[TB] scenario 4: multiple fibers");
        applyStimulus(s4c, s4p0, s4p1, 0, 1'b0, 1'b1, make_exp(4, 1, 0, 5, 3, 1, 3, 9));
        wait_drain("s4");
        do_flush();

        // 5: flush after two joined beats, then a clean restart
        $display("[TB] scenario 5: flush mid-stream");
        applyStimulus(s5w, s5w, s5w, 0, 1'b0, 1'b0, make_exp(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        #1;
        checkOutput("s5.mid_data_count", 64'(data_count), 64'd2);
        checkOutput("s5.mid_cycle_count", cycle_count, 64'd3);
        checkOutput("s5.mid_done", 64'(done), 64'd0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("s5.flush_data_count", 64'(data_count), 64'd0);
        checkOutput("s5.flush_cycle_count", cycle_count, 64'd0);
        checkOutput("s5.flush_last_fiber_len", 64'(last_fiber_len), 64'd0);
        checkOutput("s5.flush_error", 64'(error), 64'd0);
        checkOutput("s5.flush_coord_ready", 64'(coord_in_ready), 64'd0);
        repeat (2) @(negedge clk);
        applyStimulus(s1c, s1p0, s1p1, 0, 1'b0, 1'b1, make_exp(5, 1, 0, 4, 1, 0, 4, 6));
        wait_drain("s5");
        do_flush();

        // 6: scenario 1 with clk_en toggling every cycle
        $display("[TB] scenario 6: clk_en toggling");
        applyStimulus(s1c, s1p0, s1p1, 0, 1'b1, 1'b1, make_exp(6, 1, 0, 4, 1, 0, 4, 6));
        wait_drain("s6");
        do_flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
